// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan driver.
// Holds the active-low segment patterns {g,f,e,d,c,b,a}, the digit count,
// the 2-bit digit-index type and the packed shadow-frame payload.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned SEG_W      = 7;

    typedef logic [1:0]       digit_idx_t;
    typedef logic [BCD_W-1:0] bcd_t;
    typedef logic [SEG_W-1:0] seg_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
    localparam seg_t SEG_BLANK = 7'h7F;

    // One displayed frame: the digits and decimal points held for a full scan
    typedef struct packed {
        logic [NUM_DIGITS-1:0][BCD_W-1:0] digit;
        logic [NUM_DIGITS-1:0]            dp;
    } frame_t;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder.
// Ports:
//   bcd   - 4-bit BCD digit; codes 10-15 decode to blank
//   seg_c - segments {g,f,e,d,c,b,a}, active-low (combinational)
module seg7_decoder
    import seg7_pkg::*;
(
    input  bcd_t bcd,
    output seg_t seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_4dig.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A prescaler divides clk into digit slots; the slot index walks 0..3 and the
// inputs are snapshotted into a shadow frame whenever the index wraps 3->0, so
// a frame never mixes old and new data. Outputs are registered (1-cycle latency
// from index/shadow to pins).
// Optional feature macro: SEG7_BLINK_EN builds per-digit blinking; when it is
// undefined blink_mask is ignored and digits are always lit while en = 1.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous reset, active-low
//   en         - 1 = display on; 0 = anodes off, scanning continues
//   digit0..3  - BCD digits, digit0 rightmost; 10-15 display blank
//   dp_mask    - bit i lights decimal point of digit i
//   blink_mask - bit i blinks digit i (SEG7_BLINK_EN builds only)
//   an         - anode enables, active-low
//   seg        - segments {g,f,e,d,c,b,a}, active-low
//   dp         - decimal point, active-low
//   scan_tick  - one-cycle pulse at each digit-slot boundary
module seg7_scan_4dig
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_TICKS = 250
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [BCD_W-1:0]      digit0,
    input  logic [BCD_W-1:0]      digit1,
    input  logic [BCD_W-1:0]      digit2,
    input  logic [BCD_W-1:0]      digit3,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic [NUM_DIGITS-1:0] an,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic                  scan_tick
);

    localparam int unsigned PRESC_W = $clog2(REFRESH_DIV);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);

    logic [PRESC_W-1:0] presc;
    digit_idx_t         idx;
    frame_t             shadow;
    logic               tc_c;
    logic               wrap_c;
    logic               blink_off_c;
    seg_t               seg_c;

    assign tc_c   = (presc == PRESC_MAX);
    assign wrap_c = tc_c && (idx == digit_idx_t'(NUM_DIGITS - 1));

    // Prescaler, slot index, slot-boundary pulse and frame snapshot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc     <= '0;
            idx       <= '0;
            scan_tick <= 1'b0;
            shadow    <= '0;
        end else begin
            scan_tick <= tc_c;
            if (tc_c) begin
                presc <= '0;
                idx   <= digit_idx_t'(idx + 2'd1);
            end else begin
                presc <= PRESC_W'(presc + 1'b1);
            end
            if (wrap_c) begin
                shadow.digit <= {digit3, digit2, digit1, digit0};
                shadow.dp    <= dp_mask;
            end
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_TICKS - 1);

    logic [BLINK_W-1:0]    blink_cnt;
    logic                  blink_phase;
    logic [NUM_DIGITS-1:0] shadow_blink;

    // Blink phase flips every BLINK_TICKS slot boundaries; mask follows the frame snapshot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            shadow_blink <= '0;
        end else begin
            if (tc_c) begin
                if (blink_cnt == BLINK_MAX) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= BLINK_W'(blink_cnt + 1'b1);
                end
            end
            if (wrap_c) begin
                shadow_blink <= blink_mask;
            end
        end
    end

    assign blink_off_c = blink_phase & shadow_blink[idx];
`else
    logic unused_blink;
    assign unused_blink = ^blink_mask;
    assign blink_off_c  = 1'b0;
`endif

    seg7_decoder u_decoder (
        .bcd   (shadow.digit[idx]),
        .seg_c (seg_c)
    );

    // Pin registers: loaded every cycle from the current slot of the shadow frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= (!en || blink_off_c) ? '1 : ~(NUM_DIGITS'(1) << idx);
            seg <= seg_c;
            dp  <= ~shadow.dp[idx];
        end
    end

endmodule

// File: tb/tb_seg7_scan_4dig.sv
// Randomised self-checking bench for seg7_scan_4dig (REFRESH_DIV=4, BLINK_TICKS=8).
// The reference derives slot, frame and blink phase from the edge count since
// reset release; the shadow frame is a plain copy of the inputs on frame edges.
`timescale 1ns/1ps
module tb_seg7_scan_4dig;

    localparam int unsigned RD = 4;
    localparam int unsigned BT = 8;
`ifdef SEG7_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [3:0] dp_mask, blink_mask;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       scan_tick;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned n_edge;
    int unsigned m_dig [4];
    bit          m_dp [4];
    bit          m_blink [4];
    logic [6:0]  seg_ref [16];

    seg7_scan_4dig #(
        .REFRESH_DIV (RD),
        .BLINK_TICKS (BT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .scan_tick  (scan_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        n_edge = 0;
        for (int i = 0; i < 4; i++) begin
            m_dig[i]   = 0;
            m_dp[i]    = 1'b0;
            m_blink[i] = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_an"},   32'(an),        32'hF);
        check({tag, "_seg"},  32'(seg),       32'h7F);
        check({tag, "_dp"},   32'(dp),        32'h1);
        check({tag, "_tick"}, 32'(scan_tick), 32'h0);
    endtask

    // One clock edge: predict the pins from the state before the edge, then compare
    task automatic step();
        int unsigned slot;
        int unsigned ticks;
        bit          phase;
        bit          off;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic        e_tick;
        @(posedge clk);
        slot  = (n_edge / RD) % 4;
        ticks = n_edge / RD;
        phase = ((ticks / BT) % 2) == 1;
        off   = !en || (BLINK_ON && phase && m_blink[slot]);
        e_an  = 4'hF;
        if (!off) e_an[slot] = 1'b0;
        e_seg = seg_ref[m_dig[slot]];
        e_dp  = !m_dp[slot];
        n_edge++;
        e_tick = (n_edge % RD) == 0;
        if ((n_edge % (4 * RD)) == 0) begin
            m_dig[0] = digit0;
            m_dig[1] = digit1;
            m_dig[2] = digit2;
            m_dig[3] = digit3;
            for (int i = 0; i < 4; i++) begin
                m_dp[i]    = dp_mask[i];
                m_blink[i] = blink_mask[i];
            end
        end
        #1;
        check("an",        32'(an),        32'(e_an));
        check("seg",       32'(seg),       32'(e_seg));
        check("dp",        32'(dp),        32'(e_dp));
        check("scan_tick", 32'(scan_tick), 32'(e_tick));
    endtask

    initial begin
        int unsigned guard;
        seg_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        reset      = 1'b0;
        en         = 1'b1;
        digit0     = 4'd0;
        digit1     = 4'd0;
        digit2     = 4'd0;
        digit3     = 4'd0;
        dp_mask    = 4'd0;
        blink_mask = 4'd0;
        model_clear();

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk);
        reset = 1'b1;

        // All zero inputs: "0000" scan
        repeat (40) step();

        // New digits mid-frame, visible from the next frame
        digit3 = 4'd3;
        digit2 = 4'd1;
        digit1 = 4'd5;
        digit0 = 4'd9;
        repeat (48) step();

        // Blank code on digit2 with its decimal point
        digit2  = 4'hC;
        dp_mask = 4'b0100;
        repeat (40) step();

        // Display disabled for 10 cycles
        en = 1'b0;
        repeat (10) step();
        en = 1'b1;
        repeat (20) step();

        // Blinking digit0 over several half-periods
        blink_mask = 4'b0001;
        repeat (160) step();

        // Random traffic
        repeat (800) begin
            if ($urandom_range(7) == 0) begin
                digit0     = 4'($urandom_range(15));
                digit1     = 4'($urandom_range(15));
                digit2     = 4'($urandom_range(15));
                digit3     = 4'($urandom_range(15));
                dp_mask    = 4'($urandom_range(15));
                blink_mask = 4'($urandom_range(15));
            end
            if ($urandom_range(15) == 0) en = ~en;
            step();
        end
        en = 1'b1;

        // Asynchronous reset in the middle of slot 2
        guard = 0;
        while ((((n_edge / RD) % 4) != 2) && (guard < 32)) begin
            step();
            guard++;
        end
        check("reach_slot2", 32'(guard < 32), 32'h1);
        step();
        reset = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        check_reset_values("held_rst");
        reset = 1'b1;
        model_clear();
        repeat (40) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
